inst_loader: RTL and testbench

Boot-time program loader that writes instruction memory from a UART byte stream. It sits between the UART receiver and the instruction memory write port. It receives a framed image, packs every four bytes into one memory word and issues word writes. The CPU is held off until the image is complete. Words are stored in the byte-swapped layout the instruction fetch path expects, so the fetch path returns the original little-endian instruction.

---
 rtl/inst_loader.sv | 165 ++++++++++++++++
 tb/tb_inst_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot-time program loader: frames a UART byte stream into byte-swapped instruction words.
// Optional trailing XOR checksum is compiled in with `define LOADER_CHECKSUM_EN.
module inst_loader #(
    parameter int unsigned MEM_WORDS = 131072,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        start,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] index_q, index_d;
    logic [23:0] shift_q, shift_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] len_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            index_q <= '0;
            shift_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            index_q <= index_d;
            shift_q <= shift_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        index_d  = index_q;
        shift_d  = shift_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        // Length arrives little-endian, so each new byte shifts in from the top.
        len_full = {rx_data, len_q[31:8]};
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    len_d = len_full;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (len_full > MEM_WORDS) begin
                            state_d = S_ERR;
                        end else if (len_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d = S_DATA;
                            index_d = '0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    shift_d = {shift_q[15:0], rx_data};
                    cnt_d   = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    if (cnt_q == 2'd3) begin
                        // First byte of the group lands in the top lane (byte-swapped layout).
                        we_d    = 1'b1;
                        waddr_d = BASE_ADDR + (index_q << 2);
                        wdata_d = {shift_q, rx_data};
                        index_d = index_q + 32'd1;
                        if (index_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_IDLE;
                    index_d = '0;
                    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign cpu_hold = (state_q != S_DONE);

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader; expected writes go through a scoreboard queue.
// Covers both builds: checksum steps are selected by LOADER_CHECKSUM_EN.
module tb_inst_loader;

    localparam int unsigned MEM_WORDS = 131072;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        start;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int vectors;
    int miscompares;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [7:0]  pl[8];

    inst_loader #(
        .MEM_WORDS(MEM_WORDS),
        .BASE_ADDR(32'h0),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .start(start),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .err(err),
        .cpu_hold(cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collects every write the DUT issues; compared against exp_q by the main sequence.
    always @(negedge clk) begin
        if (rst_n && we) got_q.push_back({waddr, wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        logic [63:0] g;
        logic [63:0] e;
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() != 0 || exp_q.size() != 0) begin
            g = (got_q.size() != 0) ? got_q.pop_front() : 64'hx;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
            chk({tag, "_write"}, g, e);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sync, length, then n words from pl; optional idle gaps and a start poke before each payload byte.
    task automatic frame(input logic [31:0] n, input bit gap, input bit poke);
        send(8'hA5);
        send(n[7:0]);
        send(n[15:8]);
        send(n[23:16]);
        send(n[31:24]);
        for (int w = 0; w < int'(n); w++) begin
            exp_q.push_back({32'(w * 4), pl[w*4], pl[w*4+1], pl[w*4+2], pl[w*4+3]});
            for (int k = 0; k < 4; k++) begin
                if (gap) begin
                    if (poke) pulse_start();
                    else idle(1);
                end
                send(pl[w*4+k]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pl = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        start    = 1'b0;
        idle(2);
        chk("reset_outs", {we, waddr, wdata, busy, done, err, cpu_hold},
            {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst_n = 1'b1;
        idle(2);

        // Noise before sync, gapped frame with start poked mid-payload.
        send(8'h00);
        send(8'hFF);
        chk("noise_ignored", {busy, done, err}, 3'b000);
        frame(2, 1'b1, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        chk("basic_pre_csum", {busy, done, cpu_hold}, 3'b101);
        send(8'hB0);
        chk("basic_done", {done, err, cpu_hold, busy}, 4'b1000);
`else
        chk("basic_done_with_we", {we, done, cpu_hold, busy}, 4'b1100);
`endif
        idle(1);
        #1;
        check_writes("basic");
        chk("we_one_cycle", {63'h0, we}, 64'h0);
        chk("wdata_held", {waddr, wdata}, {32'h4, 32'h93052000});

        // Re-arm, then rx_valid held high across the whole frame.
        pulse_start();
        chk("rearm_idle", {done, cpu_hold, busy}, 3'b010);
        frame(2, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send(8'hB0);
`endif
        chk("stream_done", {done, err}, 2'b10);
        idle(1);
        #1;
        check_writes("stream");

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        frame(2, 1'b0, 1'b0);
        send(8'hB1);
        chk("csum_bad", {err, done, busy, cpu_hold}, 4'b1001);
        idle(1);
        #1;
        check_writes("csum_bad");
`endif

        // Zero-length image.
        pulse_start();
        frame(0, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        chk("n0_in_csum", {busy, done}, 2'b10);
        send(8'h00);
`endif
        chk("n0_done", {done, err, cpu_hold}, 3'b100);
        idle(2);
        #1;
        check_writes("n0");

        // Oversized count: error on the 4th length byte.
        pulse_start();
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send(8'h02);
        chk("big_len_pending", {busy, err}, 2'b10);
        send(8'h00);
        chk("big_len_err", {err, done, busy, cpu_hold}, 4'b1001);
        send(8'h13);
        send(8'h05);
        chk("err_sticky", {err, done}, 2'b10);
        idle(1);
        #1;
        check_writes("big_len");

        // Asynchronous reset after two payload bytes.
        pulse_start();
        send(8'hA5);
        send(8'h02);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        send(8'h13);
        send(8'h05);
        #2;
        rst_n = 1'b0;
        #2;
        chk("midreset_outs", {we, waddr, wdata, busy, done, err, cpu_hold},
            {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        idle(1);
        rst_n = 1'b1;
        send(8'h10);
        send(8'h00);
        idle(2);
        #1;
        check_writes("midreset");
        frame(2, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send(8'hB0);
`endif
        chk("after_reset_done", {done, err}, 2'b10);
        idle(1);
        #1;
        check_writes("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
